// File: rtl/mac_accelerator.sv
// Pipelined multiply / multiply-accumulate unit with a valid/ready handshake on both sides.
// Products pass through PIPE register stages and then one accumulate/output stage; a stall freezes all of it.
module mac_accelerator #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned PIPE      = 2,
    parameter bit          SIGNED    = 1'b0,
    parameter bit          SAT       = 1'b0,
    parameter int unsigned ACC_WIDTH = 2 * WIDTH + 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MAC   = 2'b01,
        OP_LAST  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    localparam int unsigned PW = 2 * WIDTH;

    logic                 stall;
    logic                 accept;
    logic [PW-1:0]        a_ext;
    logic [PW-1:0]        b_ext;
    logic [PW-1:0]        prod;

    logic [PIPE-1:0]      vld_q;
    op_e                  op_q  [PIPE];
    logic [PW-1:0]        prd_q [PIPE];

    logic                 tail_v;
    op_e                  tail_op;
    logic                 emit;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] acc_sum;
    logic [ACC_WIDTH-1:0] result;
    logic                 res_ovf;
    logic [WIDTH-1:0]     sat_val;
    logic [WIDTH-1:0]     res_data;

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_ovf_q, out_ovf_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !reset && !stall;
    assign accept   = in_valid && in_ready;

    // Extending both operands to 2*WIDTH first makes a same-width multiply exact for either signedness.
    always_comb begin
        if (SIGNED) begin
            a_ext = PW'($signed(in_a));
            b_ext = PW'($signed(in_b));
        end else begin
            a_ext = PW'(in_a);
            b_ext = PW'(in_b);
        end
        prod = a_ext * b_ext;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < PIPE; i++) begin
                op_q[i]  <= OP_MUL;
                prd_q[i] <= '0;
            end
        end else if (!stall) begin
            vld_q[0] <= accept;
            op_q[0]  <= op_e'(in_mode);
            prd_q[0] <= prod;
            for (int unsigned i = 1; i < PIPE; i++) begin
                vld_q[i] <= vld_q[i-1];
                op_q[i]  <= op_q[i-1];
                prd_q[i] <= prd_q[i-1];
            end
        end
    end

    always_comb begin
        tail_v  = vld_q[PIPE-1];
        tail_op = op_q[PIPE-1];
        emit    = tail_v && (tail_op == OP_MUL || tail_op == OP_LAST);
        if (SIGNED) begin
            prod_ext = ACC_WIDTH'($signed(prd_q[PIPE-1]));
        end else begin
            prod_ext = ACC_WIDTH'(prd_q[PIPE-1]);
        end
        acc_sum = acc_q + prod_ext;
        result  = (tail_op == OP_LAST) ? acc_sum : prod_ext;
        // Signed results fit only when every bit from WIDTH-1 upward equals the sign bit.
        if (SIGNED) begin
            res_ovf = !((&result[ACC_WIDTH-1:WIDTH-1]) || !(|result[ACC_WIDTH-1:WIDTH-1]));
            sat_val = result[ACC_WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            res_ovf = |result[ACC_WIDTH-1:WIDTH];
            sat_val = '1;
        end
        res_data = (SAT && res_ovf) ? sat_val : result[WIDTH-1:0];
    end

    always_comb begin
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        if (!stall) begin
            out_valid_d = emit;
            if (emit) begin
                out_data_d = res_data;
                out_ovf_d  = res_ovf;
            end
            if (tail_v) begin
                case (tail_op)
                    OP_MUL:   acc_d = acc_q;
                    OP_MAC:   acc_d = acc_sum;
                    OP_LAST:  acc_d = '0;
                    OP_CLEAR: acc_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_overflow = out_ovf_q;
    assign busy         = (|vld_q) || (|acc_q) || out_valid_q;

endmodule

// File: tb/tb_mac_accelerator.sv
// Self-checking bench: three mac_accelerator variants (unsigned/trunc, unsigned/sat, signed/sat)
// share stimulus; a table of hand-derived vectors plus an arithmetic reference model with a scoreboard.
module tb_mac_accelerator;

    localparam logic [1:0] M_MUL   = 2'b00;
    localparam logic [1:0] M_MAC   = 2'b01;
    localparam logic [1:0] M_LAST  = 2'b10;
    localparam logic [1:0] M_CLEAR = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_a, in_b;
    logic [1:0]  in_mode;
    logic        out_ready;
    logic        rdy [3];
    logic        ov  [3];
    logic [31:0] od  [3];
    logic        oo  [3];
    logic        bz  [3];

    int n_tests;
    int n_fail;
    bit sb_en;

    always #5 clk = ~clk;

    mac_accelerator #(.WIDTH(32), .PIPE(2), .SIGNED(0), .SAT(0)) u_d0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(ov[0]),
        .out_ready(out_ready), .out_data(od[0]), .out_overflow(oo[0]), .busy(bz[0]));

    mac_accelerator #(.WIDTH(32), .PIPE(2), .SIGNED(0), .SAT(1)) u_d1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(ov[1]),
        .out_ready(out_ready), .out_data(od[1]), .out_overflow(oo[1]), .busy(bz[1]));

    mac_accelerator #(.WIDTH(32), .PIPE(2), .SIGNED(1), .SAT(1)) u_d2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(ov[2]),
        .out_ready(out_ready), .out_data(od[2]), .out_overflow(oo[2]), .busy(bz[2]));

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] a, b;
        bit          has_out;
        logic [31:0] d0, d1, d2;
        bit          o0, o1, o2;
    } vec_t;

    typedef struct {
        logic [2:0][31:0] d;
        logic [2:0]       o;
    } exp_t;

    vec_t        tbl [$];
    exp_t        sbq [$];
    logic [71:0] macc [3];

    function automatic vec_t mk(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                                input bit h, input logic [31:0] d0, input bit o0,
                                input logic [31:0] d1, input bit o1,
                                input logic [31:0] d2, input bit o2);
        vec_t v;
        v.mode = m; v.a = a; v.b = b; v.has_out = h;
        v.d0 = d0; v.d1 = d1; v.d2 = d2; v.o0 = o0; v.o1 = o1; v.o2 = o2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Reference: exact integer arithmetic, wrapped to a 72-bit accumulator, judged against the output range.
    function automatic void model_accept(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        exp_t               e;
        logic signed [127:0] pa, pb, prod, accv, val, lo, hi, clamp;
        logic [71:0]        wrapped;
        bit                 sg, st, ovf;
        for (int c = 0; c < 3; c++) begin
            sg   = (c == 2);
            st   = (c != 0);
            pa   = {{96{sg & a[31]}}, a};
            pb   = {{96{sg & b[31]}}, b};
            prod = pa * pb;
            accv = {{56{sg & macc[c][71]}}, macc[c]};
            val  = accv + prod;
            wrapped = val[71:0];
            case (m)
                M_MAC:   macc[c] = wrapped;
                M_CLEAR: macc[c] = '0;
                M_LAST: begin
                    val = {{56{sg & wrapped[71]}}, wrapped};
                    macc[c] = '0;
                end
                default: val = prod;
            endcase
            lo    = sg ? -128'sh80000000 : 128'sd0;
            hi    = sg ? 128'sh7FFFFFFF : 128'shFFFFFFFF;
            ovf   = (val < lo) || (val > hi);
            clamp = (val < lo) ? lo : hi;
            e.o[c] = ovf;
            e.d[c] = (ovf && st) ? clamp[31:0] : val[31:0];
        end
        if (m == M_MUL || m == M_LAST) sbq.push_back(e);
    endfunction

    task automatic sb_check();
        exp_t e;
        if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_extra: unexpected output %h, none expected", od[0]);
        end else begin
            e = sbq.pop_front();
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("sb_valid%0d", c), ov[c], 1);
                chk($sformatf("sb_data%0d", c), od[c], e.d[c]);
                chk($sformatf("sb_ovf%0d", c), oo[c], e.o[c]);
            end
        end
    endtask

    // One cycle: drive at the falling edge, then judge what the next rising edge will do.
    task automatic step(input bit v, input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                        input bit ordy, output bit took);
        @(negedge clk);
        in_valid  = v;
        in_mode   = m;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        #1;
        took = v && rdy[0];
        if (sb_en) begin
            if (ov[0] && out_ready) sb_check();
            if (took) model_accept(m, a, b);
        end
    endtask

    task automatic drain(input int n);
        bit t;
        int k;
        for (int i = 0; i < n; i++) step(0, M_MUL, 0, 0, 1, t);
        k = 0;
        while ((sbq.size() != 0 || ov[0]) && k < 60) begin
            step(0, M_MUL, 0, 0, 1, t);
            k++;
        end
        chk("drain_left", sbq.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("rst_ready%0d", c), rdy[c], 0);
            chk($sformatf("rst_valid%0d", c), ov[c], 0);
            chk($sformatf("rst_ovf%0d", c), oo[c], 0);
            chk($sformatf("rst_data%0d", c), od[c], 0);
            chk($sformatf("rst_busy%0d", c), bz[c], 0);
        end
        @(negedge clk);
        reset = 1'b0;
        sbq.delete();
        for (int c = 0; c < 3; c++) macc[c] = '0;
        #1;
        chk("rst_release_ready", rdy[0], 1);
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 9))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit t, seen;
        int k;

        n_tests = 0; n_fail = 0; sb_en = 1'b0;
        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = M_MUL; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) macc[c] = '0;

        tbl.push_back(mk(M_MUL,   32'd6, 32'd7, 1, 32'd42, 0, 32'd42, 0, 32'd42, 0));
        tbl.push_back(mk(M_MAC,   32'd2, 32'd3, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(M_MAC,   32'd4, 32'd5, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(M_LAST,  32'd1, 32'd1, 1, 32'd27, 0, 32'd27, 0, 32'd27, 0));
        tbl.push_back(mk(M_LAST,  32'd2, 32'd2, 1, 32'd4, 0, 32'd4, 0, 32'd4, 0));
        tbl.push_back(mk(M_MUL,   32'h10000, 32'h10000, 1, 32'h0, 1, 32'hFFFFFFFF, 1, 32'h7FFFFFFF, 1));
        tbl.push_back(mk(M_MUL,   32'hFFFFFFFD, 32'd5, 1, 32'hFFFFFFF1, 1, 32'hFFFFFFFF, 1, 32'hFFFFFFF1, 0));
        tbl.push_back(mk(M_MUL,   32'hFFFFFFFF, 32'd1, 1, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0));
        tbl.push_back(mk(M_MUL,   32'h80000000, 32'h80000000, 1, 32'h0, 1, 32'hFFFFFFFF, 1, 32'h7FFFFFFF, 1));
        tbl.push_back(mk(M_MUL,   32'h80000000, 32'd1, 1, 32'h80000000, 0, 32'h80000000, 0, 32'h80000000, 0));
        tbl.push_back(mk(M_MUL,   32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 1, 32'hFFFFFFFF, 1, 32'h7FFFFFFF, 1));
        tbl.push_back(mk(M_MUL,   32'h10000, 32'hFFFF8000, 1, 32'h80000000, 1, 32'hFFFFFFFF, 1, 32'h80000000, 0));
        tbl.push_back(mk(M_MUL,   32'h10000, 32'hFFFF7FFF, 1, 32'h7FFF0000, 1, 32'hFFFFFFFF, 1, 32'h80000000, 1));
        tbl.push_back(mk(M_MAC,   32'd5, 32'd5, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(M_CLEAR, 32'h1234, 32'h5678, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(M_LAST,  32'd2, 32'd2, 1, 32'd4, 0, 32'd4, 0, 32'd4, 0));
        tbl.push_back(mk(M_MAC,   32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(M_LAST,  32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'd2, 1, 32'hFFFFFFFF, 1, 32'd2, 0));
        tbl.push_back(mk(M_MAC,   32'hFFFFFFFF, 32'h7FFFFFFF, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(M_LAST,  32'hFFFFFFFF, 32'd2, 1, 32'h7FFFFFFF, 1, 32'hFFFFFFFF, 1, 32'h80000000, 1));
        tbl.push_back(mk(M_MAC,   32'd2, 32'd3, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(M_MUL,   32'd7, 32'd7, 1, 32'd49, 0, 32'd49, 0, 32'd49, 0));
        tbl.push_back(mk(M_LAST,  32'd1, 32'd1, 1, 32'd7, 0, 32'd7, 0, 32'd7, 0));

        do_reset();

        foreach (tbl[i]) begin
            t = 0;
            for (int w = 0; w < 10 && !t; w++) step(1, tbl[i].mode, tbl[i].a, tbl[i].b, 1, t);
            chk($sformatf("tbl%0d_accept", i), t, 1);
            if (tbl[i].has_out) begin
                seen = 0;
                for (int w = 0; w < 10 && !seen; w++) begin
                    step(0, M_MUL, 0, 0, 1, t);
                    seen = ov[0];
                end
                chk($sformatf("tbl%0d_valid", i), seen, 1);
                chk($sformatf("tbl%0d_d0", i), od[0], tbl[i].d0);
                chk($sformatf("tbl%0d_o0", i), oo[0], tbl[i].o0);
                chk($sformatf("tbl%0d_d1", i), od[1], tbl[i].d1);
                chk($sformatf("tbl%0d_o1", i), oo[1], tbl[i].o1);
                chk($sformatf("tbl%0d_d2", i), od[2], tbl[i].d2);
                chk($sformatf("tbl%0d_o2", i), oo[2], tbl[i].o2);
            end
        end

        do_reset();
        sb_en = 1'b1;

        // Latency: result visible after exactly three rising edges, counting the accepting one.
        step(1, M_MUL, 32'd6, 32'd7, 1, t);
        chk("lat_accept", t, 1);
        step(0, M_MUL, 0, 0, 1, t); chk("lat_edge1", ov[0], 0);
        step(0, M_MUL, 0, 0, 1, t); chk("lat_edge2", ov[0], 0);
        step(0, M_MUL, 0, 0, 1, t); chk("lat_edge3", ov[0], 1); chk("lat_data", od[0], 42);
        drain(2);

        // Back-to-back MULs into a stalled consumer, then release.
        k = 1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            step(k <= 4, M_MUL, 32'(k), 32'(k), cyc >= 8, t);
            if (ov[0] && !out_ready) begin
                chk("stall_in_ready", rdy[0], 0);
                chk("stall_held", od[0], 1);
            end
            if (t) k++;
        end
        chk("stall_accepted", k, 5);
        drain(4);

        // Clear between accumulations, then everything must go idle.
        step(1, M_MAC, 32'd5, 32'd5, 1, t);
        step(1, M_CLEAR, 32'hDEAD, 32'hBEEF, 1, t);
        step(1, M_LAST, 32'd2, 32'd2, 1, t);
        drain(6);
        for (int c = 0; c < 3; c++) chk($sformatf("clear_busy%0d", c), bz[c], 0);

        // Reset while a MAC and a MUL are in flight: neither may surface afterwards.
        step(1, M_MAC, 32'd10, 32'd10, 1, t);
        step(1, M_MUL, 32'd3, 32'd3, 1, t);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, M_MUL, 0, 0, 1, t);
            chk("post_reset_quiet", ov[0], 0);
        end
        step(1, M_LAST, 32'd1, 32'd1, 1, t);
        chk("post_reset_accept", t, 1);
        drain(4);

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), rnd_op(), rnd_op(),
                 $urandom_range(0, 9) < 6, t);
        end
        drain(6);
        for (int c = 0; c < 3; c++) chk($sformatf("rand_busy%0d", c), bz[c], macc[c] != '0);
        step(1, M_CLEAR, 0, 0, 1, t);
        chk("final_clear_accept", t, 1);
        drain(6);
        for (int c = 0; c < 3; c++) chk($sformatf("final_busy%0d", c), bz[c], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
